operand_issue_ctrl: RTL and testbench
=====================================

// Module: operand_issue_ctrl
// PURPOSE
//  Consumer side of the register scoreboard: holds one decoded LC-3b instruction, stalls it until its
//  source/dest registers are ready, then issues it downstream and marks its dest busy. Drives the
//  scoreboard's set-busy write port; the writeback stage owns the set-ready port. Sits between
//  decode and execute. Includes a same-cycle writeback bypass and a stall-cycle counter.
// PARAMETERS
//  STALL_W    16  width of stall_count (saturating)
//  BYPASS_EN  1   1: same-cycle writeback of a source reg counts as ready; 0: wait for scoreboard bit
// PORTS
//  clk           in   1        clock, all state on posedge
//  reset_n       in   1        asynchronous active-low reset
//  flush         in   1        sync; discard held instruction
//  in_valid      in   1        decode presents instruction
//  in_ready      out  1        block accepts instruction this cycle
//  in_sr1/in_sr2 in   3 each   source register indices (lc3b_reg)
//  in_sr1_used   in   1        sr1 is read by instruction
//  in_sr2_used   in   1        sr2 is read by instruction
//  in_dr         in   3        destination register index
//  in_dr_used    in   1        instruction writes dr
//  sb_ready      in   8        scoreboard ready bits, 1 = register value valid
//  wb_valid      in   1        writeback retiring a reg this cycle (same pulse as scoreboard set-ready)
//  wb_reg        in   3        register being retired
//  sb_set_busy   out  1        scoreboard set-busy strobe
//  sb_busy_idx   out  3        register to mark busy
//  out_valid     out  1        issued instruction valid to execute
//  out_ready     in   1        execute accepts
//  out_sr1/out_sr2/out_dr out 3 each  held indices; out_dr_used out 1
//  hazard_stall  out  1        held instruction blocked by a register hazard this cycle
//  stall_count   out  STALL_W  cycles with hazard_stall=1, saturating
// BEHAVIOUR
//  Reset (reset_n=0, async): state EMPTY, held fields 0, stall_count 0; in_ready=1, out_valid=0,
//   sb_set_busy=0, sb_busy_idx=0, hazard_stall=0.
//  States: EMPTY (nothing held), HELD (instruction latched). Capture occurs on in_valid&in_ready.
//  src_ok(x) = !used(x) | sb_ready[x] | (BYPASS_EN & wb_valid & wb_reg==x).
//  dst_ok    = !dr_used | sb_ready[dr]. No bypass on dest: scoreboard gives set-ready priority on
//   same-index collision, so issuing a dest on its retire cycle would leave it wrongly ready.
//  clear = HELD & src_ok(sr1) & src_ok(sr2) & dst_ok. out_valid = clear (combinational).
//  hazard_stall = HELD & !clear. out_valid may drop if clear drops; no payload change while HELD.
//  Issue = out_valid & out_ready: sb_set_busy = issue & dr_used, sb_busy_idx = held dr (0 otherwise).
//  in_ready = EMPTY | issue (back-to-back). On issue with in_valid, new instr latched, stays HELD;
//   its hazard check next cycle sees the updated scoreboard (busy write lands on the same edge).
//  Transitions: EMPTY->HELD on capture; HELD->EMPTY on issue w/o capture; HELD->HELD on stall or
//   issue+capture.
//  flush (priority over all): next state EMPTY, no capture, sb_set_busy=0, out_valid forced 0,
//   in_ready=0 that cycle. stall_count unaffected.
//  Latency: instruction with no hazards and out_ready=1 issues the cycle after capture.
//  stall_count += 1 per hazard_stall cycle, holds at 2^STALL_W-1; cleared only by reset.
//  Reset mid-stall: held instruction dropped, no busy strobe emitted.
// TESTING
//  1 No hazard: capture ADD R1<-R2,R3, all sb_ready=8'hFF, out_ready=1 -> out_valid next cycle,
//    sb_set_busy=1 idx=1, stall_count=0.
//  2 RAW: sb_ready=8'hFD (R1 busy), instr reads R1 -> hazard_stall 3 cycles; wb_valid,wb_reg=1 on
//    4th -> issue that cycle (BYPASS_EN=1), stall_count=3; with BYPASS_EN=0 issue one cycle later.
//  3 WAW: dr=R4, sb_ready[4]=0, wb_reg=4 same cycle -> no issue that cycle; issues next cycle once
//    sb_ready[4]=1.
//  4 Back-to-back: two independent instrs, out_ready=1 constant -> issued consecutive cycles,
//    in_ready stays 1; dependent second instr (reads first's dr) -> stalls until wb.
//  5 Backpressure+flush: clear but out_ready=0 for 2 cycles, then flush -> EMPTY, no sb_set_busy.
//  6 Saturation/reset: STALL_W=4, 20 stall cycles -> stall_count=15; assert reset_n low mid-stall ->
//    all outputs to reset values immediately (async).

Source files
------------

// File: rtl/operand_issue_ctrl.sv
// Operand issue controller: holds one decoded LC-3b instruction until its registers are ready,
// then issues it downstream and asks the scoreboard to mark its destination busy.
module operand_issue_ctrl #(
    parameter int STALL_W   = 16,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_sr1,
    input  logic [2:0]         in_sr2,
    input  logic               in_sr1_used,
    input  logic               in_sr2_used,
    input  logic [2:0]         in_dr,
    input  logic               in_dr_used,
    input  logic [7:0]         sb_ready,
    input  logic               wb_valid,
    input  logic [2:0]         wb_reg,
    output logic               sb_set_busy,
    output logic [2:0]         sb_busy_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_sr1,
    output logic [2:0]         out_sr2,
    output logic [2:0]         out_dr,
    output logic               out_dr_used,
    output logic               hazard_stall,
    output logic [STALL_W-1:0] stall_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sr1_q, sr1_d;
    logic [2:0]         sr2_q, sr2_d;
    logic [2:0]         dr_q, dr_d;
    logic               sr1_used_q, sr1_used_d;
    logic               sr2_used_q, sr2_used_d;
    logic               dr_used_q, dr_used_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    // Per-register source readiness: scoreboard bit, or a same-cycle retire when bypass is enabled.
    logic [7:0] src_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_src_rdy
            assign src_rdy[gi] = sb_ready[gi] | (BYPASS_EN & wb_valid & (wb_reg == 3'(gi)));
        end
    endgenerate

    logic held;
    logic sr1_ok, sr2_ok, dst_ok;
    logic clear;
    logic issue;
    logic capture;

    always_comb begin
        held    = (state_q == ST_HELD);
        sr1_ok  = !sr1_used_q | src_rdy[sr1_q];
        sr2_ok  = !sr2_used_q | src_rdy[sr2_q];
        // Destination must see the real scoreboard bit: a retire on the same index wins over set-busy.
        dst_ok  = !dr_used_q | sb_ready[dr_q];
        clear   = held & sr1_ok & sr2_ok & dst_ok;

        hazard_stall = held & !clear;
        out_valid    = clear & !flush;
        issue        = out_valid & out_ready;
        in_ready     = !flush & (!held | issue);
        capture      = in_valid & in_ready;

        sb_set_busy  = issue & dr_used_q;
        sb_busy_idx  = sb_set_busy ? dr_q : 3'd0;

        out_sr1      = sr1_q;
        out_sr2      = sr2_q;
        out_dr       = dr_q;
        out_dr_used  = dr_used_q;
        stall_count  = stall_q;
    end

    always_comb begin
        state_d    = state_q;
        sr1_d      = sr1_q;
        sr2_d      = sr2_q;
        dr_d       = dr_q;
        sr1_used_d = sr1_used_q;
        sr2_used_d = sr2_used_q;
        dr_used_d  = dr_used_q;
        stall_d    = stall_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (capture) begin
            state_d    = ST_HELD;
            sr1_d      = in_sr1;
            sr2_d      = in_sr2;
            dr_d       = in_dr;
            sr1_used_d = in_sr1_used;
            sr2_used_d = in_sr2_used;
            dr_used_d  = in_dr_used;
        end else if (issue) begin
            state_d = ST_EMPTY;
        end

        // Saturating hazard counter; flush does not touch it.
        if (hazard_stall && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            sr1_q      <= 3'd0;
            sr2_q      <= 3'd0;
            dr_q       <= 3'd0;
            sr1_used_q <= 1'b0;
            sr2_used_q <= 1'b0;
            dr_used_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            dr_q       <= dr_d;
            sr1_used_q <= sr1_used_d;
            sr2_used_q <= sr2_used_d;
            dr_used_q  <= dr_used_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Directed bench: one DUT with bypass and 16-bit counter, one without bypass and a 4-bit counter,
// both driven by the same stimulus.
module tb_operand_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic [2:0] in_sr1, in_sr2, in_dr;
    logic       in_sr1_used, in_sr2_used, in_dr_used;
    logic [7:0] sb_ready;
    logic       wb_valid;
    logic [2:0] wb_reg;
    logic       out_ready;

    logic        a_in_ready, a_sb_set_busy, a_out_valid, a_out_dr_used, a_hazard;
    logic [2:0]  a_busy_idx, a_out_sr1, a_out_sr2, a_out_dr;
    logic [15:0] a_stall;
    logic        b_in_ready, b_sb_set_busy, b_out_valid, b_out_dr_used, b_hazard;
    logic [2:0]  b_busy_idx, b_out_sr1, b_out_sr2, b_out_dr;
    logic [3:0]  b_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_issue_ctrl #(.STALL_W(16), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sr1(in_sr1), .in_sr2(in_sr2), .in_sr1_used(in_sr1_used), .in_sr2_used(in_sr2_used),
        .in_dr(in_dr), .in_dr_used(in_dr_used),
        .sb_ready(sb_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .sb_set_busy(a_sb_set_busy), .sb_busy_idx(a_busy_idx),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sr1(a_out_sr1), .out_sr2(a_out_sr2), .out_dr(a_out_dr), .out_dr_used(a_out_dr_used),
        .hazard_stall(a_hazard), .stall_count(a_stall)
    );

    operand_issue_ctrl #(.STALL_W(4), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sr1(in_sr1), .in_sr2(in_sr2), .in_sr1_used(in_sr1_used), .in_sr2_used(in_sr2_used),
        .in_dr(in_dr), .in_dr_used(in_dr_used),
        .sb_ready(sb_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .sb_set_busy(b_sb_set_busy), .sb_busy_idx(b_busy_idx),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sr1(b_out_sr1), .out_sr2(b_out_sr2), .out_dr(b_out_dr), .out_dr_used(b_out_dr_used),
        .hazard_stall(b_hazard), .stall_count(b_stall)
    );

    // Advance one clock; inputs are then changed 1ns after the edge and checked 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2,
                           input logic [2:0] d, input logic ud);
        in_valid = 1'b1;
        in_sr1 = s1; in_sr1_used = u1;
        in_sr2 = s2; in_sr2_used = u2;
        in_dr = d;   in_dr_used = ud;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0; wb_reg = 3'd0; out_ready = 1'b0;
        sb_ready = 8'hFF;
        present(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #2;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        checks++; if ({a_sb_set_busy, a_busy_idx} !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b/%0d expected 0/0", a_sb_set_busy, a_busy_idx); end
        checks++; if ({a_hazard, a_stall} !== 17'd0) begin errors++; $display("FAIL reset_stall: got hz=%b cnt=%0d expected 0/0", a_hazard, a_stall); end
        checks++; if ({a_out_sr1, a_out_sr2, a_out_dr, a_out_dr_used} !== 10'd0) begin errors++; $display("FAIL reset_fields: got %0d/%0d/%0d/%b expected 0", a_out_sr1, a_out_sr2, a_out_dr, a_out_dr_used); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_no_hazard();
        do_reset();
        sb_ready = 8'hFF; out_ready = 1'b1;
        present(3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1);
        #2;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL nohaz_capture_cycle: got ov=%b ir=%b expected 0/1", a_out_valid, a_in_ready); end
        tick();
        in_valid = 1'b0;
        #2;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL nohaz_out_valid: got %b expected 1", a_out_valid); end
        checks++; if (a_sb_set_busy !== 1'b1 || a_busy_idx !== 3'd1) begin errors++; $display("FAIL nohaz_busy: got %b idx %0d expected 1 idx 1", a_sb_set_busy, a_busy_idx); end
        checks++; if ({a_out_sr1, a_out_sr2, a_out_dr} !== {3'd2, 3'd3, 3'd1}) begin errors++; $display("FAIL nohaz_payload: got %0d/%0d/%0d expected 2/3/1", a_out_sr1, a_out_sr2, a_out_dr); end
        checks++; if (a_hazard !== 1'b0 || a_stall !== 16'd0) begin errors++; $display("FAIL nohaz_stall: got hz=%b cnt=%0d expected 0/0", a_hazard, a_stall); end
        tick();
        #2;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL nohaz_empty_after: got ov=%b ir=%b expected 0/1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_raw();
        do_reset();
        sb_ready = 8'hFD; out_ready = 1'b1;
        present(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (a_hazard !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL raw_stall_c%0d: got hz=%b ov=%b expected 1/0", c, a_hazard, a_out_valid); end
            tick();
        end
        wb_valid = 1'b1; wb_reg = 3'd1;
        #2;
        checks++; if (a_out_valid !== 1'b1 || a_sb_set_busy !== 1'b1 || a_busy_idx !== 3'd3) begin errors++; $display("FAIL raw_bypass_issue: got ov=%b sb=%b idx=%0d expected 1/1/3", a_out_valid, a_sb_set_busy, a_busy_idx); end
        checks++; if (a_stall !== 16'd3) begin errors++; $display("FAIL raw_stall_count: got %0d expected 3", a_stall); end
        checks++; if (b_out_valid !== 1'b0 || b_hazard !== 1'b1) begin errors++; $display("FAIL raw_nobypass_wait: got ov=%b hz=%b expected 0/1", b_out_valid, b_hazard); end
        tick();
        wb_valid = 1'b0; sb_ready = 8'hFF;
        #2;
        checks++; if (b_out_valid !== 1'b1 || b_busy_idx !== 3'd3) begin errors++; $display("FAIL raw_nobypass_issue: got ov=%b idx=%0d expected 1/3", b_out_valid, b_busy_idx); end
        checks++; if (b_stall !== 4'd4) begin errors++; $display("FAIL raw_nobypass_count: got %0d expected 4", b_stall); end
        checks++; if (a_out_valid !== 1'b0 || a_stall !== 16'd3) begin errors++; $display("FAIL raw_after_issue: got ov=%b cnt=%0d expected 0/3", a_out_valid, a_stall); end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        sb_ready = 8'hEF; out_ready = 1'b1;
        present(3'd2, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_reg = 3'd4;
        #2;
        checks++; if (a_out_valid !== 1'b0 || a_hazard !== 1'b1 || a_sb_set_busy !== 1'b0) begin errors++; $display("FAIL waw_no_dest_bypass: got ov=%b hz=%b sb=%b expected 0/1/0", a_out_valid, a_hazard, a_sb_set_busy); end
        tick();
        wb_valid = 1'b0; sb_ready = 8'hFF;
        #2;
        checks++; if (a_out_valid !== 1'b1 || a_sb_set_busy !== 1'b1 || a_busy_idx !== 3'd4) begin errors++; $display("FAIL waw_issue: got ov=%b sb=%b idx=%0d expected 1/1/4", a_out_valid, a_sb_set_busy, a_busy_idx); end
        checks++; if (a_stall !== 16'd1) begin errors++; $display("FAIL waw_count: got %0d expected 1", a_stall); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        sb_ready = 8'hFF; out_ready = 1'b1;
        present(3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1);
        tick();
        present(3'd4, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1);
        #2;
        checks++; if (a_out_valid !== 1'b1 || a_busy_idx !== 3'd1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got ov=%b idx=%0d ir=%b expected 1/1/1", a_out_valid, a_busy_idx, a_in_ready); end
        tick();
        sb_ready = 8'hFD;
        present(3'd6, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1);
        #2;
        checks++; if (a_out_valid !== 1'b1 || a_busy_idx !== 3'd6 || a_out_sr1 !== 3'd4 || a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_second: got ov=%b idx=%0d sr1=%0d ir=%b expected 1/6/4/1", a_out_valid, a_busy_idx, a_out_sr1, a_in_ready); end
        tick();
        sb_ready = 8'hBD;
        in_valid = 1'b0;
        #2;
        checks++; if (a_hazard !== 1'b1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_dep_stall: got hz=%b ov=%b ir=%b expected 1/0/0", a_hazard, a_out_valid, a_in_ready); end
        tick();
        #2;
        checks++; if (a_hazard !== 1'b1) begin errors++; $display("FAIL b2b_dep_stall2: got %b expected 1", a_hazard); end
        tick();
        wb_valid = 1'b1; wb_reg = 3'd6;
        #2;
        checks++; if (a_out_valid !== 1'b1 || a_busy_idx !== 3'd7 || a_stall !== 16'd2) begin errors++; $display("FAIL b2b_dep_issue: got ov=%b idx=%0d cnt=%0d expected 1/7/2", a_out_valid, a_busy_idx, a_stall); end
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        sb_ready = 8'hFF; out_ready = 1'b0;
        present(3'd2, 1'b1, 3'd3, 1'b1, 3'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (a_out_valid !== 1'b1 || a_sb_set_busy !== 1'b0 || a_in_ready !== 1'b0 || a_hazard !== 1'b0) begin errors++; $display("FAIL bp_hold_c%0d: got ov=%b sb=%b ir=%b hz=%b expected 1/0/0/0", c, a_out_valid, a_sb_set_busy, a_in_ready, a_hazard); end
            tick();
        end
        flush = 1'b1; out_ready = 1'b1;
        present(3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1);
        #2;
        checks++; if (a_out_valid !== 1'b0 || a_sb_set_busy !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle: got ov=%b sb=%b ir=%b expected 0/0/0", a_out_valid, a_sb_set_busy, a_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #2;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_sb_set_busy !== 1'b0) begin errors++; $display("FAIL flush_empty: got ov=%b ir=%b sb=%b expected 0/1/0", a_out_valid, a_in_ready, a_sb_set_busy); end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        sb_ready = 8'hFD; out_ready = 1'b1;
        present(3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        #2;
        checks++; if (b_stall !== 4'd15) begin errors++; $display("FAIL sat_count4: got %0d expected 15", b_stall); end
        checks++; if (a_stall !== 16'd20) begin errors++; $display("FAIL sat_count16: got %0d expected 20", a_stall); end
        checks++; if (a_hazard !== 1'b1) begin errors++; $display("FAIL sat_still_stalling: got %b expected 1", a_hazard); end
        reset_n = 1'b0;
        #1;
        checks++; if (a_stall !== 16'd0 || b_stall !== 4'd0 || a_hazard !== 1'b0) begin errors++; $display("FAIL async_reset_stall: got a=%0d b=%0d hz=%b expected 0/0/0", a_stall, b_stall, a_hazard); end
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_sb_set_busy !== 1'b0 || a_out_sr1 !== 3'd0 || a_out_dr !== 3'd0) begin errors++; $display("FAIL async_reset_outs: got ir=%b ov=%b sb=%b sr1=%0d dr=%0d expected 1/0/0/0/0", a_in_ready, a_out_valid, a_sb_set_busy, a_out_sr1, a_out_dr); end
        sb_ready = 8'hFF;
        tick();
        reset_n = 1'b1;
        #2;
        checks++; if (a_sb_set_busy !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_drop_instr: got sb=%b ov=%b expected 0/0", a_sb_set_busy, a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_raw();
        test_waw();
        test_back_to_back();
        test_flush();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
